// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and helpers for the divider cell chain
// Purpose: operand/result widths, pipeline latency and collector depth used by the
//          issue stage, the cell chain and the result collector.
// Ports: none (package).
package div_pkg;

    localparam int N     = 5;           // dividend width
    localparam int M     = 3;           // divisor width
    localparam int QW    = N - M + 1;   // quotient width (one cell per quotient bit)
    localparam int RW    = M;           // remainder width
    localparam int LAT   = 2 * QW;      // two register stages per cell
    localparam int DEPTH = 4;           // result buffer entries and issue credit limit

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    localparam int PW  = clog2(DEPTH);      // buffer pointer width
    localparam int CW  = PW + 1;            // occupancy width, holds 0..DEPTH
    localparam int IFW = clog2(LAT + 1);    // in-flight counter width, holds 0..LAT

endpackage

// File: rtl/div_collect_fifo.sv
// rtl/div_collect_fifo.sv - DEPTH-entry register FIFO for quotient/remainder results
// Purpose: stores results captured from the last divider cell until the consumer pops them.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   push        write push_data at the tail (dropped when full)
//   push_data   {quotient, remainder}
//   pop         advance the head (no-op when empty)
//   pop_data    head entry, zero when empty
//   count       occupancy 0..DEPTH
//   empty       count == 0
module div_collect_fifo
    import div_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [QW+RW-1:0]   push_data,
    input  logic               pop,
    output logic [QW+RW-1:0]   pop_data,
    output logic [CW-1:0]      count,
    output logic               empty
);

    logic [QW+RW-1:0] mem_q [DEPTH];
    logic [QW+RW-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end

        // DEPTH is a power of two, so pointer wrap is plain overflow.
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);

        pop_data = empty ? '0 : mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/div_result_collector.sv
// rtl/div_result_collector.sv - tracks divider ops in flight and buffers their results
// Purpose: follows each op through the non-stallable cell pipeline, captures the last cell's
//          quotient/remainder into a FIFO and grants issue credits so the FIFO never overflows.
// Config: DIV_COLLECT_ERR_EN adds a sticky err output for protocol violations.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_vld / in_rdy      op issued into cell 0 / credit available
//   pipe_quot, pipe_rem  last-cell results, valid LAT cycles after issue
//   out_vld / out_rdy    head entry valid / consumer accepts it
//   out_quot, out_rem    head entry, zero when empty
//   count                FIFO occupancy
//   err                  (DIV_COLLECT_ERR_EN only) sticky violation flag
module div_result_collector
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [QW-1:0]   pipe_quot,
    input  logic [RW-1:0]   pipe_rem,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [QW-1:0]   out_quot,
    output logic [RW-1:0]   out_rem,
    output logic [CW-1:0]   count
`ifdef DIV_COLLECT_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int SW = ((IFW > CW) ? IFW : CW) + 1;

    logic [LAT-1:0]   vld_sr_q, vld_sr_d;
    logic [IFW-1:0]   inflight_q, inflight_d;
    logic             accepted;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [QW+RW-1:0] head_data;
    logic [SW-1:0]    credit_used;

    div_collect_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({pipe_quot, pipe_rem}),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (count),
        .empty     (fifo_empty)
    );

    always_comb begin
        // Every op in flight has a reserved slot, so a push can always land.
        credit_used = SW'(inflight_q) + SW'(count);
        in_rdy      = (credit_used < SW'(DEPTH));
        accepted    = in_vld & in_rdy;
        push        = vld_sr_q[LAT-1];
        out_vld     = ~fifo_empty;
        pop         = out_vld & out_rdy;
        {out_quot, out_rem} = head_data;

        vld_sr_d   = {vld_sr_q[LAT-2:0], accepted};
        inflight_d = inflight_q + IFW'(accepted) - IFW'(push);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_sr_q   <= '0;
            inflight_q <= '0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef DIV_COLLECT_ERR_EN
    logic err_q, err_d;
    logic fifo_full;

    always_comb begin
        fifo_full = (count == CW'(DEPTH));
        err_d     = err_q | (in_vld & ~in_rdy) | (push & fifo_full);
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_div_result_collector.sv
// tb/tb_div_result_collector.sv - directed self-checking bench for div_result_collector
module tb_div_result_collector;
    import div_pkg::*;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [QW-1:0] pipe_quot;
    logic [RW-1:0] pipe_rem;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [QW-1:0] out_quot;
    logic [RW-1:0] out_rem;
    logic [CW-1:0] count;
`ifdef DIV_COLLECT_ERR_EN
    logic          err;
`endif

    div_result_collector dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .pipe_quot (pipe_quot),
        .pipe_rem  (pipe_rem),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .count     (count)
`ifdef DIV_COLLECT_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the cell chain: whatever is presented with in_vld appears LAT cycles later.
    logic [QW+RW-1:0] in_data = '0;
    logic [QW+RW-1:0] pipe_sr [LAT];
    always @(posedge clk) begin
        pipe_sr[0] <= in_data;
        for (int i = 1; i < LAT; i++) begin
            pipe_sr[i] <= pipe_sr[i-1];
        end
    end
    assign {pipe_quot, pipe_rem} = pipe_sr[LAT-1];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int               m_inflight;
    int               m_count;
    logic [LAT-1:0]   m_sr;
    logic [QW+RW-1:0] m_fly[$];
    logic [QW+RW-1:0] m_q[$];
    int               obs_acc;
    int               obs_pops;
    int               max_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_count    = 0;
        m_sr       = '0;
        m_fly.delete();
        m_q.delete();
        obs_acc  = 0;
        obs_pops = 0;
    endtask

    // Check the current cycle against the model, advance the model, then move to the next cycle.
    task automatic tick();
        bit               rdy, acc, push, pop;
        logic [QW+RW-1:0] hd;
        rdy = (m_inflight + m_count) < DEPTH;
        chk("in_rdy", 32'(in_rdy), 32'(rdy));
        chk("out_vld", 32'(out_vld), 32'(m_count != 0));
        chk("count", 32'(count), 32'(m_count));
        if (m_count != 0) begin
            hd = m_q[0];
            chk("out_quot", 32'(out_quot), 32'(hd[QW+RW-1:RW]));
            chk("out_rem", 32'(out_rem), 32'(hd[RW-1:0]));
        end else begin
            chk("out_quot_empty", 32'(out_quot), 32'd0);
            chk("out_rem_empty", 32'(out_rem), 32'd0);
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (in_vld && in_rdy) obs_acc++;
        if (out_vld && out_rdy) obs_pops++;

        acc  = in_vld && rdy;
        push = m_sr[LAT-1];
        pop  = out_rdy && (m_count != 0);
        if (acc) m_fly.push_back(in_data);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(m_fly.pop_front());
        m_count    = m_count + int'(push) - int'(pop);
        m_inflight = m_inflight + int'(acc) - int'(push);
        m_sr       = {m_sr[LAT-2:0], acc};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        chk({tag, "_out_quot"}, 32'(out_quot), 32'd0);
        chk({tag, "_out_rem"}, 32'(out_rem), 32'd0);
        chk({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               a0;
        int               p0;
        int               guard;
        int               seen;
        logic [39:0]      pat;

        model_reset();
        max_cnt = 0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Single op: issue 2/1, visible LAT+1 cycles later, pop clears it.
        in_vld  = 1'b1;
        in_data = {3'b010, 3'b001};
        tick();
        in_vld = 1'b0;
        repeat (LAT) begin
            chk("single_early_vld", 32'(out_vld), 32'd0);
            tick();
        end
        chk("single_vld", 32'(out_vld), 32'd1);
        chk("single_quot", 32'(out_quot), 32'd2);
        chk("single_rem", 32'(out_rem), 32'd1);
        out_rdy = 1'b1;
        tick();
        chk("single_popped", 32'(out_vld), 32'd0);
        out_rdy = 1'b0;

        // Back-pressure: only DEPTH issues get credit.
        a0 = obs_acc;
        in_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 6'(8 + i);
            chk("bp_in_rdy", 32'(in_rdy), 32'(i < 4));
            tick();
        end
        in_vld = 1'b0;
        chk("bp_accepted", 32'(obs_acc - a0), 32'd4);
        repeat (4) tick();
        chk("bp_count_full", 32'(count), 32'd4);
        chk("bp_rdy_full", 32'(in_rdy), 32'd0);
        repeat (2) tick();
        chk("bp_count_hold", 32'(count), 32'd4);
        out_rdy = 1'b1;
        chk("bp_head_quot", 32'(out_quot), 32'd1);
        chk("bp_head_rem", 32'(out_rem), 32'd0);
        tick();
        chk("bp_rdy_back", 32'(in_rdy), 32'd1);
        chk("bp_count_after_pop", 32'(count), 32'd3);
        repeat (4) tick();
        chk("bp_drained", 32'(out_vld), 32'd0);
        out_rdy = 1'b0;

        // Reset mid-run with ops in flight: nothing may emerge afterwards.
        in_vld = 1'b1;
        repeat (3) begin
            in_data = in_data + 1'b1;
            tick();
        end
        in_vld = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        seen = 0;
        repeat (LAT + 4) begin
            seen = seen + int'(out_vld);
            tick();
        end
        chk("midrun_no_ghost", 32'(seen), 32'd0);

        // Streaming: 20 ops accepted and delivered in order, buffer never above 1.
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        a0      = obs_acc;
        p0      = obs_pops;
        max_cnt = 0;
        guard   = 0;
        while ((obs_acc - a0) < 20 && guard < 300) begin
            in_data = in_data + 1'b1;
            tick();
            guard++;
        end
        in_vld = 1'b0;
        repeat (LAT + 3) tick();
        chk("stream_accepted", 32'(obs_acc - a0), 32'd20);
        chk("stream_results", 32'(obs_pops - p0), 32'd20);
        chk("stream_count_le1", 32'(max_cnt <= 1), 32'd1);

        // Irregular consumer with continuous issue: overlapping push/pop and pointer wrap.
        pat    = 40'hF0C3_5A96_3C;
        in_vld = 1'b1;
        a0     = obs_acc;
        p0     = obs_pops;
        for (int i = 0; i < 40; i++) begin
            out_rdy = pat[i];
            in_data = in_data + 1'b1;
            tick();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (LAT + 6) tick();
        chk("wrap_many_pushes", 32'(obs_acc - a0 > 9), 32'd1);
        chk("wrap_balance", 32'(obs_pops - p0), 32'(obs_acc - a0));
        chk("wrap_empty", 32'(count), 32'd0);

`ifdef DIV_COLLECT_ERR_EN
        // Issue against no credit raises a sticky err.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        chk("err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            in_data = in_data + 1'b1;
            chk("err_timing", 32'(err), 32'(i >= 5));
            tick();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (LAT + 6) tick();
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_no_extra", 32'(obs_pops - p0), 32'(obs_acc - a0));
        rstn = 1'b0;
        #1;
        chk("err_reset", 32'(err), 32'd0);
        rstn = 1'b1;
        model_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
